// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MOD up/down counter with synchronous load,
// wrap or saturate behaviour at the range ends, a combinational
// terminal-count flag, a one-cycle wrap pulse and a sticky overflow flag.
// Count range is 0..MOD-1. MOD may be as large as 2**WIDTH, so MOD and the
// top-of-range value are carried in WIDTH+1 bits.
module mod_updown_counter #(
    parameter int unsigned    WIDTH = 8,
    parameter logic [WIDTH:0] MOD   = {1'b1, {WIDTH{1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             en,
    input  logic             up_dn,     // 1 = up, 0 = down
    input  logic             sat,       // 0 = wrap, 1 = saturate
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Top of the count range, kept one bit wider than the counter so that a
    // modulus of 2**WIDTH does not truncate to zero.
    localparam logic [WIDTH:0]   MAX_EXT = MOD - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_CNT = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;
    logic             ovf_set;
    logic             at_max;
    logic             at_zero;

    // Range-end detection, compared at WIDTH+1 bits against the top value.
    assign at_max  = ({1'b0, count_q} == MAX_EXT);
    assign at_zero = (count_q == '0);

    // Terminal count: the enabled, non-loading step about to leave the range.
    assign tc = en & ~load & (up_dn ? at_max : at_zero);

    // Next count and wrap pulse: load beats enable, enable beats hold.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            // Out-of-range load values clamp to the top of the range.
            if ({1'b0, load_val} > MAX_EXT) begin
                count_d = MAX_CNT;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    ovf_set = 1'b1;
                    if (!sat) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE_CNT;
                end
            end else begin
                if (at_zero) begin
                    ovf_set = 1'b1;
                    if (!sat) begin
                        count_d = MAX_CNT;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE_CNT;
                end
            end
        end
    end

    // Sticky overflow: a set condition on the same edge wins over the clear.
    assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);

    // State register; reset clears everything, including a pending wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (MOD=10 and MOD=16, WIDTH=4)
// share one stimulus stream. Stimulus predicts each edge's outcome from a
// plain-integer reference model and queues it; a monitor pops and compares
// after every rising edge.
module tb_mod_updown_counter;

    localparam int MOD_A = 10;
    localparam int MOD_B = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b0;
    logic       sat      = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       ovf_clr  = 1'b0;

    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

    mod_updown_counter #(.WIDTH(4), .MOD(5'd10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    mod_updown_counter #(.WIDTH(4), .MOD(5'd16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit wrap;
        bit ovf;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } exp_t;

    exp_t sb_q[$];
    st_t  m_a, m_b;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: step by +/-1; leaving 0..mod-1 is an overflow, which either
    // wraps modulo mod or leaves the count where it was.
    function automatic st_t model_next(st_t s, int mod, bit e, bit up, bit sa,
                                       bit ld, int lv, bit clr);
        st_t n;
        int  nxt;
        bit  hit;
        hit    = 1'b0;
        n.cnt  = s.cnt;
        n.wrap = 1'b0;
        if (ld) begin
            n.cnt = (lv > mod - 1) ? mod - 1 : lv;
        end else if (e) begin
            nxt = s.cnt + (up ? 1 : -1);
            if (nxt < 0 || nxt >= mod) begin
                hit = 1'b1;
                if (!sa) begin
                    n.cnt  = (nxt + mod) % mod;
                    n.wrap = 1'b1;
                end
            end else begin
                n.cnt = nxt;
            end
        end
        n.ovf = hit ? 1'b1 : (clr ? 1'b0 : s.ovf);
        return n;
    endfunction

    function automatic bit model_tc(st_t s, int mod, bit e, bit up, bit ld);
        return e && !ld && (up ? (s.cnt == mod - 1) : (s.cnt == 0));
    endfunction

    // One clock of stimulus: drive on the falling edge, check tc, queue the
    // expected post-edge state, then wait for the rising edge.
    task automatic step(input bit e, input bit up, input bit sa, input bit ld,
                        input int lv, input bit clr);
        exp_t x;
        @(negedge clk);
        en       = e;
        up_dn    = up;
        sat      = sa;
        load     = ld;
        load_val = 4'(lv);
        ovf_clr  = clr;
        #1;
        check("tc_mod10", tc_a, model_tc(m_a, MOD_A, e, up, ld));
        check("tc_mod16", tc_b, model_tc(m_b, MOD_B, e, up, ld));
        m_a = model_next(m_a, MOD_A, e, up, sa, ld, lv, clr);
        m_b = model_next(m_b, MOD_B, e, up, sa, ld, lv, clr);
        x.a = m_a;
        x.b = m_b;
        sb_q.push_back(x);
        @(posedge clk);
    endtask

    // Asynchronous reset between edges; state must clear without a clock and
    // stay cleared across an edge with en=1.
    task automatic async_reset();
        #3;
        en    = 1'b1;
        up_dn = 1'b1;
        load  = 1'b0;
        rst   = 1'b0;
        #1;
        check("rst_count_mod10", count_a, 0);
        check("rst_wrap_mod10",  wrap_a,  0);
        check("rst_ovf_mod10",   ovf_a,   0);
        check("rst_count_mod16", count_b, 0);
        check("rst_wrap_mod16",  wrap_b,  0);
        check("rst_ovf_mod16",   ovf_b,   0);
        @(posedge clk);
        #2;
        check("rst_hold_mod10", count_a, 0);
        check("rst_hold_mod16", count_b, 0);
        @(negedge clk);
        en = 1'b0;
        #2;
        rst = 1'b1;
        m_a = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
        m_b = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
    endtask

    // Monitor: one queued expectation per rising edge.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("count_mod10", count_a, x.a.cnt);
            check("wrap_mod10",  wrap_a,  x.a.wrap);
            check("ovf_mod10",   ovf_a,   x.a.ovf);
            check("count_mod16", count_b, x.b.cnt);
            check("wrap_mod16",  wrap_b,  x.b.wrap);
            check("ovf_mod16",   ovf_b,   x.b.ovf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_a = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
        m_b = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};

        // Reset asserted from time zero, released at 12 ns.
        #1;
        check("init_count_mod10", count_a, 0);
        check("init_wrap_mod10",  wrap_a,  0);
        check("init_ovf_mod10",   ovf_a,   0);
        check("init_count_mod16", count_b, 0);
        #11;
        rst = 1'b1;

        // Free-running up count in wrap mode: two full laps of MOD=10.
        repeat (20) step(1, 1, 0, 0, 0, 0);

        // Clear ovf, load 7, then saturating down count past zero.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 7, 0);
        repeat (10) step(1, 0, 1, 0, 0, 0);

        // Clamped load, then load together with enable.
        step(0, 0, 0, 1, 13, 0);
        step(1, 1, 0, 1, 1, 0);

        // ovf_clr on a wrapping edge, then on an idle edge.
        step(0, 1, 0, 1, 9, 0);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Asynchronous reset while the wrap pulse is high.
        step(0, 1, 0, 1, 9, 0);
        step(1, 1, 0, 0, 0, 0);
        async_reset();

        // Asynchronous reset mid-count.
        step(0, 1, 0, 1, 5, 0);
        async_reset();

        // Both range ends with a direction toggle: back-to-back wraps.
        step(0, 1, 0, 1, 15, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
